// File: rtl/s_mem_index_checker.sv
// Sweeps all 256 S-memory locations and checks that s[i] == i.
// A tag pipeline as deep as the RAM read latency pairs each returned byte with the address that produced it.
module s_mem_index_checker #(
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] address_out,
  output logic       write_enable_out,
  input  logic [7:0] data_in,
  output logic       check_done,
  output logic       check_pass,
  output logic [8:0] mismatch_count,
  output logic [7:0] first_bad_addr,
  output logic       first_bad_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state_r, state_s;
  logic [8:0] cnt_r, cnt_s;
  logic [READ_LATENCY-1:0] pipe_valid_r;
  logic [7:0] pipe_tag_r [READ_LATENCY];
  logic       cmp_bad_s;
  logic [8:0] mismatch_s;

  assign write_enable_out = 1'b0;

  // state and shared read/drain counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 9'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // next state: cnt_r is the read address in READ and the drain count in DRAIN
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_s = 9'd0;
        if (start) state_s = READ;
        else       state_s = IDLE;
      end
      READ: begin
        if (cnt_r == 9'd255) begin
          state_s = DRAIN;
          cnt_s   = 9'd0;
        end else begin
          cnt_s   = cnt_r + 9'd1;
        end
      end
      DRAIN: begin
        if (cnt_r == 9'(READ_LATENCY - 1)) begin
          state_s = FINISH;
          cnt_s   = 9'd0;
        end else begin
          cnt_s   = cnt_r + 9'd1;
        end
      end
      FINISH: begin
        state_s = FINISH;
        cnt_s   = 9'd0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 9'd0;
      end
    endcase
  end

  // compare the pipeline head tag against the returning read data
  always_comb begin
    cmp_bad_s  = 1'b0;
    mismatch_s = mismatch_count;
    if (pipe_valid_r[READ_LATENCY-1] && (data_in != pipe_tag_r[READ_LATENCY-1])) begin
      cmp_bad_s  = 1'b1;
      mismatch_s = mismatch_count + 9'd1;
    end else begin
      cmp_bad_s  = 1'b0;
    end
  end

  // address register, tag pipeline and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      address_out     <= 8'd0;
      pipe_valid_r    <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_tag_r[i] <= 8'd0;
      check_done      <= 1'b0;
      check_pass      <= 1'b0;
      mismatch_count  <= 9'd0;
      first_bad_addr  <= 8'd0;
      first_bad_valid <= 1'b0;
    end else begin
      address_out <= (state_s == READ) ? cnt_s[7:0] : 8'd0;
      if (state_r == IDLE) begin
        pipe_valid_r <= '0;
      end else begin
        for (int i = READ_LATENCY - 1; i > 0; i--) begin
          pipe_valid_r[i] <= pipe_valid_r[i-1];
          pipe_tag_r[i]   <= pipe_tag_r[i-1];
        end
        pipe_valid_r[0] <= (state_r == READ);
        pipe_tag_r[0]   <= cnt_r[7:0];
      end
      if (cmp_bad_s) begin
        mismatch_count <= mismatch_s;
        if (!first_bad_valid) begin
          first_bad_addr  <= pipe_tag_r[READ_LATENCY-1];
          first_bad_valid <= 1'b1;
        end
      end
      // the last compare lands in the final DRAIN cycle, so pass uses the updated count
      check_done <= (state_s == FINISH);
      check_pass <= (state_s == FINISH) && (mismatch_s == 9'd0);
    end
  end

endmodule

// File: tb/tb_s_mem_index_checker.sv
// Drives two checkers (read latency 1 and 3) from one S-memory model and
// compares sweep timing and results against a reference computed from memory contents.
module tb_s_mem_index_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] mem [256];

  logic [7:0] a1, a3, di1, di3, fb1, fb3;
  logic       we1, we3, d1, d3, p1, p3, fv1, fv3;
  logic [8:0] mm1, mm3;
  logic [7:0] dl1;
  logic [7:0] dl3 [3];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  s_mem_index_checker #(.READ_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .address_out(a1), .write_enable_out(we1),
    .data_in(di1), .check_done(d1), .check_pass(p1), .mismatch_count(mm1),
    .first_bad_addr(fb1), .first_bad_valid(fv1));

  s_mem_index_checker #(.READ_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .start(start), .address_out(a3), .write_enable_out(we3),
    .data_in(di3), .check_done(d3), .check_pass(p3), .mismatch_count(mm3),
    .first_bad_addr(fb3), .first_bad_valid(fv3));

  // synchronous RAM read paths with 1 and 3 cycles of latency
  always @(posedge clk) begin
    dl1    <= a1;
    dl3[0] <= a3;
    dl3[1] <= dl3[0];
    dl3[2] <= dl3[1];
  end
  assign di1 = mem[dl1];
  assign di3 = mem[dl3[2]];

  task automatic fill_identity();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // one full sweep on both DUTs, checked cycle by cycle, then against the model
  task automatic run_sweep(input string name, input bit do_reset, input bit hold_start);
    int exp_cnt;
    int exp_first;
    int exp_addr;
    bit exp_pass;
    exp_cnt = 0;
    exp_first = -1;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] != 8'(i)) begin
        exp_cnt++;
        if (exp_first < 0) exp_first = i;
      end
    end
    exp_pass = (exp_cnt == 0);
    if (do_reset) pulse_reset();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = hold_start;
    for (int c = 1; c <= 266; c++) begin
      @(negedge clk);
      exp_addr = (c <= 256) ? c - 1 : 0;
      total++;
      if (a1 !== 8'(exp_addr)) begin
        bad++; $display("FAIL %s addr1 c=%0d got=%0d exp=%0d", name, c, a1, exp_addr);
      end
      total++;
      if (a3 !== 8'(exp_addr)) begin
        bad++; $display("FAIL %s addr3 c=%0d got=%0d exp=%0d", name, c, a3, exp_addr);
      end
      total++;
      if (d1 !== (c >= 258) || p1 !== (c >= 258 && exp_pass)) begin
        bad++; $display("FAIL %s done1 c=%0d got=%b/%b exp=%b/%b", name, c, d1, p1, c >= 258, c >= 258 && exp_pass);
      end
      total++;
      if (d3 !== (c >= 260) || p3 !== (c >= 260 && exp_pass)) begin
        bad++; $display("FAIL %s done3 c=%0d got=%b/%b exp=%b/%b", name, c, d3, p3, c >= 260, c >= 260 && exp_pass);
      end
      total++;
      if (we1 !== 1'b0 || we3 !== 1'b0) begin
        bad++; $display("FAIL %s we c=%0d got=%b%b exp=00", name, c, we1, we3);
      end
      if (hold_start && c == 262) start = 1'b0;
      if (hold_start && c == 263) start = 1'b1;
    end
    start = 1'b0;
    total++;
    if (mm1 !== 9'(exp_cnt) || mm3 !== 9'(exp_cnt)) begin
      bad++; $display("FAIL %s count got=%0d/%0d exp=%0d", name, mm1, mm3, exp_cnt);
    end
    total++;
    if (fv1 !== (exp_first >= 0) || fv3 !== (exp_first >= 0)) begin
      bad++; $display("FAIL %s first_valid got=%b/%b exp=%b", name, fv1, fv3, exp_first >= 0);
    end
    total++;
    if (fb1 !== ((exp_first >= 0) ? 8'(exp_first) : 8'd0) || fb3 !== ((exp_first >= 0) ? 8'(exp_first) : 8'd0)) begin
      bad++; $display("FAIL %s first_addr got=%0d/%0d exp=%0d", name, fb1, fb3, exp_first);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({a1, a3, we1, we3, d1, d3, p1, p3, mm1, mm3, fb1, fb3, fv1, fv3} !== '0) begin
        bad++; $display("FAIL reset outputs got a=%0d/%0d done=%b%b mm=%0d/%0d exp=all zero", a1, a3, d1, d3, mm1, mm3);
      end
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (d1 !== 1'b0 || d3 !== 1'b0 || a1 !== 8'd0 || a3 !== 8'd0) begin
        bad++; $display("FAIL idle got done=%b%b a=%0d/%0d exp=0", d1, d3, a1, a3);
      end
    end
  endtask

  task automatic test_identity();
    fill_identity();
    run_sweep("identity", 1'b1, 1'b0);
  endtask

  task automatic test_two_bad();
    fill_identity();
    mem[17] = 8'h00;
    mem[200] = 8'hFF;
    run_sweep("two_bad", 1'b1, 1'b0);
  endtask

  task automatic test_patterns();
    fill_const(8'h00);
    run_sweep("all_zero", 1'b1, 1'b0);
    fill_const(8'hAA);
    run_sweep("all_aa", 1'b1, 1'b0);
    fill_identity();
    mem[255] = 8'h00;
    run_sweep("last_bad", 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      fill_identity();
      for (int n = $urandom_range(0, 6); n > 0; n--)
        mem[$urandom_range(0, 255)] = 8'($urandom);
      run_sweep("random", 1'b1, 1'b0);
    end
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    run_sweep("random_full", 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    fill_const(8'h00);
    pulse_reset();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (100) @(negedge clk);
    total++;
    if (mm1 !== 9'd97 || mm3 !== 9'd95) begin
      bad++; $display("FAIL partial count got=%0d/%0d exp=97/95", mm1, mm3);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({a1, a3, d1, d3, p1, p3, mm1, mm3, fb1, fb3, fv1, fv3} !== '0) begin
      bad++; $display("FAIL midrun_clear got a=%0d/%0d mm=%0d/%0d fv=%b%b exp=all zero", a1, a3, mm1, mm3, fv1, fv3);
    end
    reset = 1'b0;
    fill_identity();
    run_sweep("after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_start_held();
    fill_identity();
    mem[3] = 8'h07;
    run_sweep("start_held", 1'b1, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_identity();
    test_two_bad();
    test_patterns();
    test_random();
    test_reset_mid_run();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
